debounce_edge_detect: RTL and testbench

Multi-channel input conditioner that turns asynchronous, bouncy board inputs (buttons, switches, external strobes) into clean per-channel levels, single-cycle edge pulses and acknowledged event flags. It sits between top-level pins and the control FSMs, and provides input synchronisation, debounce, edge detection and event capture in one block.

---
 rtl/debounce_pkg.sv | 17 +
 rtl/debounce_channel.sv | 69 ++++++
 rtl/debounce_edge_detect.sv | 78 +++++++
 tb/tb_debounce_edge_detect.sv | 223 ++++++++++++++++++++++
 4 files changed

// File: rtl/debounce_pkg.sv
// Shared constants and helpers for the multi-channel input conditioner.
package debounce_pkg;

  // Event source selection
  localparam int unsigned EVT_RISE = 0;
  localparam int unsigned EVT_FALL = 1;
  localparam int unsigned EVT_BOTH = 2;

  // Debounce counter width: clog2 of the stable-cycle count, never below one bit
  function automatic int unsigned cnt_width(input int unsigned n);
    int unsigned w;
    w = (n <= 1) ? 1 : $clog2(n);
    if (w < 1) w = 1;
    return w;
  endfunction

endpackage

// File: rtl/debounce_channel.sv
// One input channel: synchroniser, debounce counter, accepted level and edge pulses.
module debounce_channel
  import debounce_pkg::*;
#(
  parameter int unsigned SYNC_STAGES  = 2,
  parameter int unsigned DEBOUNCE_CYC = 1_000_000,
  parameter logic        INIT_LEVEL   = 1'b0
) (
  input  logic clk,
  input  logic rst_n,
  input  logic sig_in,
  output logic level,
  output logic pos_edge,
  output logic neg_edge,
  output logic rise_c,
  output logic fall_c
);

  localparam int unsigned    CW      = cnt_width(DEBOUNCE_CYC);
  localparam logic [CW-1:0]  CNT_MAX = CW'(DEBOUNCE_CYC - 1);

  logic [SYNC_STAGES-1:0] sync_q;
  logic [CW-1:0]          cnt;
  logic                   sync;
  logic                   mismatch_c;
  logic                   accept_c;

  assign sync = sync_q[SYNC_STAGES-1];

  // Metastability chain; stage 0 samples the raw pin
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= {SYNC_STAGES{INIT_LEVEL}};
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], sig_in};
    end
  end

  // Acceptance decision: the mismatch has persisted for the full stable window
  always_comb begin
    mismatch_c = (sync != level);
    accept_c   = mismatch_c && (cnt == CNT_MAX);
    rise_c     = accept_c && sync;
    fall_c     = accept_c && !sync;
  end

  // Stable-cycle counter, accepted level and one-cycle edge pulses
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt      <= '0;
      level    <= INIT_LEVEL;
      pos_edge <= 1'b0;
      neg_edge <= 1'b0;
    end else begin
      pos_edge <= rise_c;
      neg_edge <= fall_c;
      // Any agreement or an acceptance restarts the count; it never wraps
      if (!mismatch_c || accept_c) begin
        cnt <= '0;
      end else begin
        cnt <= cnt + CW'(1);
      end
      if (accept_c) begin
        level <= sync;
      end
    end
  end

endmodule

// File: rtl/debounce_edge_detect.sv
// Multi-channel input conditioner: per-channel debounce plus sticky, acknowledged event flags.
module debounce_edge_detect
  import debounce_pkg::*;
#(
  parameter int unsigned CH           = 4,
  parameter int unsigned SYNC_STAGES  = 2,
  parameter int unsigned DEBOUNCE_CYC = 1_000_000,
  parameter logic        INIT_LEVEL   = 1'b0,
  parameter int unsigned EVT_MODE     = EVT_BOTH
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic [CH-1:0] sig_in,
  output logic [CH-1:0] level,
  output logic [CH-1:0] pos_edge,
  output logic [CH-1:0] neg_edge,
  output logic [CH-1:0] evt_pending,
  input  logic [CH-1:0] evt_ack,
  output logic [CH-1:0] evt_overflow
);

  logic [CH-1:0] rise_c;
  logic [CH-1:0] fall_c;
  logic [CH-1:0] evt_c;

  // Independent conditioning path per channel
  for (genvar i = 0; i < CH; i++) begin : g_ch
    debounce_channel #(
      .SYNC_STAGES  (SYNC_STAGES),
      .DEBOUNCE_CYC (DEBOUNCE_CYC),
      .INIT_LEVEL   (INIT_LEVEL)
    ) u_channel (
      .clk      (clk),
      .rst_n    (rst_n),
      .sig_in   (sig_in[i]),
      .level    (level[i]),
      .pos_edge (pos_edge[i]),
      .neg_edge (neg_edge[i]),
      .rise_c   (rise_c[i]),
      .fall_c   (fall_c[i])
    );
  end

  // Event source select; uses the pre-register acceptance so flags move with level
  always_comb begin
    evt_c = '0;
    if (EVT_MODE == EVT_RISE) begin
      evt_c = rise_c;
    end else if (EVT_MODE == EVT_FALL) begin
      evt_c = fall_c;
    end else begin
      evt_c = rise_c | fall_c;
    end
  end

  // Sticky pending/overflow flags; a new event beats a coincident ack
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      evt_pending  <= '0;
      evt_overflow <= '0;
    end else begin
      for (int i = 0; i < CH; i++) begin
        if (evt_c[i]) begin
          evt_pending[i] <= 1'b1;
          if (evt_pending[i] && !evt_ack[i]) begin
            evt_overflow[i] <= 1'b1;
          end else if (evt_pending[i] && evt_ack[i]) begin
            evt_overflow[i] <= 1'b0;
          end
        end else if (evt_ack[i] && evt_pending[i]) begin
          evt_pending[i]  <= 1'b0;
          evt_overflow[i] <= 1'b0;
        end
      end
    end
  end

endmodule

// File: tb/tb_debounce_edge_detect.sv
// Self-checking bench for debounce_edge_detect: directed scenarios then random bounce traffic.
module tb_debounce_edge_detect;
  import debounce_pkg::*;

  localparam int unsigned CH = 2;
  localparam int unsigned SS = 2;
  localparam int unsigned DC = 4;
  localparam int unsigned HL = SS + DC;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [CH-1:0] sig_in;
  logic [CH-1:0] evt_ack;
  logic [CH-1:0] level, pos_edge, neg_edge, evt_pending, evt_overflow;

  int unsigned vectors     = 0;
  int unsigned miscompares = 0;

  // Reference state: raw input history plus expected outputs
  logic [CH-1:0] hist[$];
  logic [CH-1:0] m_level, m_pos, m_neg, m_pend, m_ovf;

  debounce_edge_detect #(
    .CH           (CH),
    .SYNC_STAGES  (SS),
    .DEBOUNCE_CYC (DC),
    .INIT_LEVEL   (1'b0),
    .EVT_MODE     (EVT_BOTH)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .sig_in       (sig_in),
    .level        (level),
    .pos_edge     (pos_edge),
    .neg_edge     (neg_edge),
    .evt_pending  (evt_pending),
    .evt_ack      (evt_ack),
    .evt_overflow (evt_overflow)
  );

  always #5 clk = ~clk;

  initial begin
    #400000;
    $display("FAIL watchdog: observed timeout, expected completion");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    hist.delete();
    for (int k = 0; k < int'(HL); k++) hist.push_back('0);
    m_level = '0; m_pos = '0; m_neg = '0; m_pend = '0; m_ovf = '0;
  endtask

  // A channel flips once the raw samples seen SS..SS+DC-1 edges ago all disagree with it
  task automatic model_edge(input logic [CH-1:0] s, input logic [CH-1:0] ack);
    logic [CH-1:0] cur;
    bit flip;
    hist.push_back(s);
    void'(hist.pop_front());
    for (int c = 0; c < int'(CH); c++) begin
      flip = 1'b1;
      for (int j = 0; j < int'(DC); j++) begin
        cur = hist[j];
        if (cur[c] == m_level[c]) flip = 1'b0;
      end
      m_pos[c] = flip && !m_level[c];
      m_neg[c] = flip && m_level[c];
      if (flip) begin
        if (m_pend[c] && !ack[c]) m_ovf[c] = 1'b1;
        else if (m_pend[c])      m_ovf[c] = 1'b0;
        m_pend[c] = 1'b1;
        m_level[c] = ~m_level[c];
      end else if (ack[c] && m_pend[c]) begin
        m_pend[c] = 1'b0;
        m_ovf[c]  = 1'b0;
      end
    end
  endtask

  task automatic check_all(input string tag);
    chk(tag, 32'({level, pos_edge, neg_edge, evt_pending, evt_overflow}),
             32'({m_level, m_pos, m_neg, m_pend, m_ovf}));
  endtask

  task automatic tick();
    @(posedge clk);
    if (rst_n) model_edge(sig_in, evt_ack);
    #1;
    check_all("cycle");
  endtask

  task automatic settle_ack();
    repeat (8) tick();
    evt_ack = '1;
    tick();
    evt_ack = '0;
  endtask

  int pat[9] = '{1, 0, 1, 1, 0, 1, 1, 1, 1};
  int pulses;
  int pulse_edge;
  int n;

  initial begin
    // Reset with both inputs high
    rst_n = 1'b0; sig_in = 2'b11; evt_ack = 2'b00;
    model_reset();
    #1;
    chk("reset_outputs", 32'({level, pos_edge, neg_edge, evt_pending, evt_overflow}), 32'd0);
    repeat (2) tick();
    rst_n = 1'b1;
    repeat (5) tick();
    chk("release_edge5_level", 32'(level), 32'd0);
    tick();
    chk("release_edge6_level", 32'(level), 32'h3);
    chk("release_edge6_pos", 32'(pos_edge), 32'h3);
    tick();
    chk("release_edge7_pos", 32'(pos_edge), 32'd0);
    sig_in = 2'b00;
    settle_ack();

    // Channel 0 rises and holds
    sig_in = 2'b01;
    repeat (5) tick();
    chk("rise0_edge5_level", 32'(level), 32'd0);
    tick();
    chk("rise0_edge6_level", 32'(level), 32'h1);
    chk("rise0_edge6_pulses", 32'({pos_edge, neg_edge}), 32'h4);
    tick();
    chk("rise0_edge7_pulses", 32'({pos_edge, neg_edge}), 32'd0);
    sig_in = 2'b00;
    settle_ack();

    // Three-cycle glitch is rejected
    sig_in = 2'b01;
    repeat (3) tick();
    sig_in = 2'b00;
    repeat (8) tick();
    chk("glitch_level_pend", 32'({level, evt_pending}), 32'd0);

    // Four-cycle pulse is accepted and released
    sig_in = 2'b01;
    repeat (4) tick();
    sig_in = 2'b00;
    repeat (2) tick();
    chk("pulse4_rise", 32'({level, pos_edge}), 32'h5);
    repeat (4) tick();
    chk("pulse4_fall", 32'({level, neg_edge}), 32'h1);
    evt_ack = 2'b11; tick(); evt_ack = 2'b00;

    // Overflow on channel 1, ack, then ack racing a new event
    sig_in = 2'b10;
    repeat (6) tick();
    sig_in = 2'b00;
    repeat (6) tick();
    chk("ovf_pend", 32'({evt_pending, evt_overflow}), 32'ha);
    evt_ack = 2'b10; tick(); evt_ack = 2'b00;
    chk("ack_clears", 32'({evt_pending, evt_overflow}), 32'd0);
    sig_in = 2'b10;
    repeat (6) tick();
    sig_in = 2'b00;
    repeat (6) tick();
    sig_in = 2'b10;
    repeat (5) tick();
    evt_ack = 2'b10; tick(); evt_ack = 2'b00;
    chk("ack_with_event", 32'({evt_pending, evt_overflow}), 32'h8);

    // Reset in the middle of a count
    sig_in = 2'b11;
    repeat (8) tick();
    sig_in = 2'b10;
    repeat (4) tick();
    rst_n = 1'b0;
    model_reset();
    #1;
    chk("midcount_reset", 32'({level, pos_edge, neg_edge, evt_pending, evt_overflow}), 32'd0);
    tick();
    rst_n = 1'b1;
    repeat (5) tick();
    chk("post_reset_edge5", 32'(level), 32'd0);
    tick();
    chk("post_reset_edge6", 32'({level, pos_edge}), 32'ha);
    sig_in = 2'b00;
    settle_ack();

    // Bounce on channel 1 yields one rise pulse
    pulses = 0; pulse_edge = 0; n = 0;
    for (int i = 0; i < 9; i++) begin
      sig_in[1] = pat[i][0];
      tick(); n++;
      if (pos_edge[1]) begin pulses++; pulse_edge = n; end
    end
    repeat (10) begin
      tick(); n++;
      if (pos_edge[1]) begin pulses++; pulse_edge = n; end
    end
    chk("bounce_pulse_count", 32'(pulses), 32'd1);
    chk("bounce_pulse_edge", 32'(pulse_edge), 32'd11);
    settle_ack();

    // Random bouncing inputs and acks against the reference
    for (int i = 0; i < 600; i++) begin
      for (int c = 0; c < int'(CH); c++) begin
        if ($urandom_range(0, 5) == 0) sig_in[c] = ~sig_in[c];
        evt_ack[c] = ($urandom_range(0, 3) == 0);
      end
      tick();
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
